fu_issue_scheduler: RTL and testbench

// - Issue scheduler between the two dispatch lanes and the shared functional units (adder, multiplier, memory port).
// - Keeps a 32-entry register scoreboard and a busy countdown per unit.
// - Grants each lane's instruction only when it is hazard-free, in program order (lane 1 is older).
// - Its stall1 output drives the dispatch unit's data_hazard input.

---
 rtl/fu_issue_scheduler.sv | 132 +++++++++++++
 tb/tb_fu_issue_scheduler.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/fu_issue_scheduler.sv
// Dual-lane in-order issue scheduler: register scoreboard plus per-unit busy countdowns
// for the shared adder, multiplier and memory port.
module fu_issue_scheduler #(
  parameter int unsigned ADD_LAT = 1,
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req1,
  input  logic [1:0]  op1,
  input  logic [4:0]  rd1,
  input  logic [4:0]  rs1_1,
  input  logic [4:0]  rs2_1,
  input  logic        req2,
  input  logic [1:0]  op2,
  input  logic [4:0]  rd2,
  input  logic [4:0]  rs1_2,
  input  logic [4:0]  rs2_2,
  input  logic        wb_valid1,
  input  logic [4:0]  wb_rd1,
  input  logic        wb_valid2,
  input  logic [4:0]  wb_rd2,
  output logic        grant1,
  output logic        grant2,
  output logic        stall1,
  output logic        stall2,
  output logic        busy_add,
  output logic        busy_mul,
  output logic        busy_mem,
  output logic [31:0] pending
);

  localparam int unsigned CW = 4;
  localparam int unsigned NREG = 32;

  localparam logic [1:0] OP_ADD   = 2'd0;
  localparam logic [1:0] OP_MUL   = 2'd1;
  localparam logic [1:0] OP_LOAD  = 2'd2;
  localparam logic [1:0] OP_STORE = 2'd3;

  localparam logic [1:0] U_ADD = 2'd0;
  localparam logic [1:0] U_MUL = 2'd1;
  localparam logic [1:0] U_MEM = 2'd2;

  function automatic logic [1:0] unit_of(input logic [1:0] op);
    if (op == OP_ADD)      return U_ADD;
    else if (op == OP_MUL) return U_MUL;
    else                   return U_MEM;
  endfunction

  function automatic logic writes_rd(input logic [1:0] op);
    return op != OP_STORE;
  endfunction

  function automatic logic reads_rs2(input logic [1:0] op);
    return op != OP_LOAD;
  endfunction

  function automatic logic [CW-1:0] next_cnt(input logic [CW-1:0] c, input logic load,
                                             input logic [CW-1:0] lat);
    if (load)          return lat;
    else if (c != '0)  return c - CW'(1);
    else               return '0;
  endfunction

  logic [CW-1:0]   cnt_add, cnt_mul, cnt_mem;
  logic [CW-1:0]   cnt_add_nxt, cnt_mul_nxt, cnt_mem_nxt;
  logic [NREG-1:0] pending_nxt;
  logic [3:0]      unit_free;
  logic [1:0]      u1, u2;
  logic            haz1, haz2, dep12, w1;
  logic            load_add, load_mul, load_mem;

  // Hazard checks and grants; writebacks deliberately do not bypass into this cycle.
  always_comb begin
    unit_free = {1'b0, cnt_mem == '0, cnt_mul == '0, cnt_add == '0};
    u1 = unit_of(op1);
    u2 = unit_of(op2);

    haz1 = pending[rs1_1] || (reads_rs2(op1) && pending[rs2_1]) ||
           (writes_rd(op1) && pending[rd1]);
    grant1 = !reset && req1 && unit_free[u1] && !haz1;

    haz2 = pending[rs1_2] || (reads_rs2(op2) && pending[rs2_2]) ||
           (writes_rd(op2) && pending[rd2]);
    w1 = grant1 && writes_rd(op1) && (rd1 != 5'd0);
    dep12 = w1 && ((rs1_2 == rd1) || (reads_rs2(op2) && (rs2_2 == rd1)) ||
                   (writes_rd(op2) && (rd2 == rd1)));
    grant2 = !reset && req2 && (grant1 || !req1) && unit_free[u2] &&
             !(grant1 && (u1 == u2)) && !haz2 && !dep12;

    stall1 = !reset && req1 && !grant1;
    stall2 = !reset && req2 && !grant2;
  end

  // Next state: countdown reloads and scoreboard update (clears first, then sets win).
  always_comb begin
    load_add = (grant1 && (u1 == U_ADD)) || (grant2 && (u2 == U_ADD));
    load_mul = (grant1 && (u1 == U_MUL)) || (grant2 && (u2 == U_MUL));
    load_mem = (grant1 && (u1 == U_MEM)) || (grant2 && (u2 == U_MEM));
    cnt_add_nxt = next_cnt(cnt_add, load_add, CW'(ADD_LAT));
    cnt_mul_nxt = next_cnt(cnt_mul, load_mul, CW'(MUL_LAT));
    cnt_mem_nxt = next_cnt(cnt_mem, load_mem, CW'(MEM_LAT));

    pending_nxt = pending;
    if (wb_valid1) pending_nxt[wb_rd1] = 1'b0;
    if (wb_valid2) pending_nxt[wb_rd2] = 1'b0;
    if (grant1 && writes_rd(op1)) pending_nxt[rd1] = 1'b1;
    if (grant2 && writes_rd(op2)) pending_nxt[rd2] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_add <= '0;
      cnt_mul <= '0;
      cnt_mem <= '0;
      pending <= '0;
    end else begin
      cnt_add <= cnt_add_nxt;
      cnt_mul <= cnt_mul_nxt;
      cnt_mem <= cnt_mem_nxt;
      pending <= pending_nxt;
    end
  end

  assign busy_add = cnt_add != '0;
  assign busy_mul = cnt_mul != '0;
  assign busy_mem = cnt_mem != '0;

endmodule

// File: tb/tb_fu_issue_scheduler.sv
// Self-checking bench for fu_issue_scheduler: per-cycle vector table through an
// expectation queue, plus hand-written reset sequences.
module tb_fu_issue_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        req1, req2, wb_valid1, wb_valid2;
  logic [1:0]  op1, op2;
  logic [4:0]  rd1, rs1_1, rs2_1, rd2, rs1_2, rs2_2, wb_rd1, wb_rd2;
  logic        grant1, grant2, stall1, stall2, busy_add, busy_mul, busy_mem;
  logic [31:0] pending;

  int checks = 0;
  int failures = 0;

  fu_issue_scheduler dut (
    .clk(clk), .reset(reset),
    .req1(req1), .op1(op1), .rd1(rd1), .rs1_1(rs1_1), .rs2_1(rs2_1),
    .req2(req2), .op2(op2), .rd2(rd2), .rs1_2(rs1_2), .rs2_2(rs2_2),
    .wb_valid1(wb_valid1), .wb_rd1(wb_rd1), .wb_valid2(wb_valid2), .wb_rd2(wb_rd2),
    .grant1(grant1), .grant2(grant2), .stall1(stall1), .stall2(stall2),
    .busy_add(busy_add), .busy_mul(busy_mul), .busy_mem(busy_mem), .pending(pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r1; logic [1:0] o1; logic [4:0] d1, a1, b1;
    logic        r2; logic [1:0] o2; logic [4:0] d2, a2, b2;
    logic        w1; logic [4:0] wr1; logic w2; logic [4:0] wr2;
    logic        g1, g2, s1, s2, ba, bm, bme;
    logic [31:0] pend;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  function automatic vec_t mk(
    input logic r1, input logic [1:0] o1, input logic [4:0] d1, a1, b1,
    input logic r2, input logic [1:0] o2, input logic [4:0] d2, a2, b2,
    input logic w1, input logic [4:0] wr1, input logic w2, input logic [4:0] wr2,
    input logic g1, g2, s1, s2, ba, bm, bme, input logic [31:0] pend);
    vec_t v;
    v.r1 = r1; v.o1 = o1; v.d1 = d1; v.a1 = a1; v.b1 = b1;
    v.r2 = r2; v.o2 = o2; v.d2 = d2; v.a2 = a2; v.b2 = b2;
    v.w1 = w1; v.wr1 = wr1; v.w2 = w2; v.wr2 = wr2;
    v.g1 = g1; v.g2 = g2; v.s1 = s1; v.s2 = s2;
    v.ba = ba; v.bm = bm; v.bme = bme; v.pend = pend;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", name, act, expv);
    end
  endtask

  task automatic drive(input vec_t v);
    req1 = v.r1; op1 = v.o1; rd1 = v.d1; rs1_1 = v.a1; rs2_1 = v.b1;
    req2 = v.r2; op2 = v.o2; rd2 = v.d2; rs1_2 = v.a2; rs2_2 = v.b2;
    wb_valid1 = v.w1; wb_rd1 = v.wr1; wb_valid2 = v.w2; wb_rd2 = v.wr2;
  endtask

  task automatic check_row(input int i, input vec_t e);
    cmp($sformatf("row%0d grant1", i), 32'(grant1), 32'(e.g1));
    cmp($sformatf("row%0d grant2", i), 32'(grant2), 32'(e.g2));
    cmp($sformatf("row%0d stall1", i), 32'(stall1), 32'(e.s1));
    cmp($sformatf("row%0d stall2", i), 32'(stall2), 32'(e.s2));
    cmp($sformatf("row%0d busy_add", i), 32'(busy_add), 32'(e.ba));
    cmp($sformatf("row%0d busy_mul", i), 32'(busy_mul), 32'(e.bm));
    cmp($sformatf("row%0d busy_mem", i), 32'(busy_mem), 32'(e.bme));
    cmp($sformatf("row%0d pending", i), pending, e.pend);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t idle;
    // op: 0 add, 1 mul, 2 load, 3 store
    idle = mk(0,0,0,0,0, 0,0,0,0,0, 0,0,0,0, 0,0,0,0,0,0,0, 32'h0);
    vecs.push_back(idle);
    vecs.push_back(mk(1,0,5,1,2, 0,0,0,0,0, 0,0,0,0, 1,0,0,0,0,0,0, 32'h0));
    vecs.push_back(mk(0,0,0,0,0, 0,0,0,0,0, 0,0,0,0, 0,0,0,0,1,0,0, 32'h20));
    vecs.push_back(mk(0,0,0,0,0, 0,0,0,0,0, 0,0,0,0, 0,0,0,0,0,0,0, 32'h20));
    // mul rd3 then dependent add on lane 2; retire r3 at end of row 5
    vecs.push_back(mk(1,1,3,1,2, 1,0,6,3,4, 0,0,0,0, 1,0,0,1,0,0,0, 32'h20));
    vecs.push_back(mk(0,0,0,0,0, 1,0,6,3,4, 1,3,0,0, 0,0,0,1,0,1,0, 32'h28));
    vecs.push_back(mk(0,0,0,0,0, 1,0,6,3,4, 0,0,0,0, 0,1,0,0,0,1,0, 32'h20));
    // two adds competing for the adder
    vecs.push_back(mk(1,0,8,1,2, 1,0,9,10,11, 0,0,0,0, 0,0,1,1,1,1,0, 32'h60));
    vecs.push_back(mk(1,0,8,1,2, 1,0,9,10,11, 0,0,0,0, 1,0,0,1,0,1,0, 32'h60));
    vecs.push_back(mk(0,0,0,0,0, 1,0,9,10,11, 0,0,0,0, 0,0,0,1,1,0,0, 32'h160));
    vecs.push_back(mk(0,0,0,0,0, 1,0,9,10,11, 0,0,0,0, 0,1,0,0,0,0,0, 32'h160));
    // lane 1 RAW on r6 blocks independent lane 2
    vecs.push_back(mk(1,0,12,6,0, 1,1,13,14,15, 0,0,0,0, 0,0,1,1,1,0,0, 32'h360));
    vecs.push_back(mk(0,0,0,0,0, 0,0,0,0,0, 1,6,1,0, 0,0,0,0,0,0,0, 32'h360));
    vecs.push_back(mk(0,0,0,0,0, 0,0,0,0,0, 1,5,1,9, 0,0,0,0,0,0,0, 32'h320));
    // load rd9 with same-edge writeback of r9; lane 2 writes x0
    vecs.push_back(mk(1,2,9,1,8, 1,0,0,0,0, 1,9,0,0, 1,1,0,0,0,0,0, 32'h100));
    vecs.push_back(mk(1,3,20,1,2, 0,0,0,0,0, 0,0,0,0, 0,0,1,0,1,0,1, 32'h300));
    vecs.push_back(mk(1,3,20,1,2, 0,0,0,0,0, 0,0,0,0, 0,0,1,0,0,0,1, 32'h300));
    vecs.push_back(mk(1,3,20,1,2, 1,2,21,22,0, 0,0,0,0, 1,0,0,1,0,0,0, 32'h300));
    vecs.push_back(mk(0,0,0,0,0, 0,0,0,0,0, 0,0,0,0, 0,0,0,0,0,0,1, 32'h300));
    vecs.push_back(mk(0,0,0,0,0, 0,0,0,0,0, 0,0,0,0, 0,0,0,0,0,0,1, 32'h300));
    // back-to-back muls: second grant five cycles after the first
    vecs.push_back(mk(1,1,0,1,2, 0,0,0,0,0, 0,0,0,0, 1,0,0,0,0,0,0, 32'h300));
    for (int k = 0; k < 4; k++)
      vecs.push_back(mk(1,1,0,1,2, 0,0,0,0,0, 0,0,0,0, 0,0,1,0,0,1,0, 32'h300));
    vecs.push_back(mk(1,1,0,1,2, 0,0,0,0,0, 0,0,0,0, 1,0,0,0,0,0,0, 32'h300));

    // reset with a request held: grants/stalls forced low
    reset = 1'b1;
    drive(idle);
    req1 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cmp("reset grant1", 32'(grant1), 32'd0);
    cmp("reset stall1", 32'(stall1), 32'd0);
    cmp("reset pending", pending, 32'h0);
    cmp("reset busy", {29'd0, busy_add, busy_mul, busy_mem}, 32'd0);
    reset = 1'b0;
    drive(idle);

    foreach (vecs[i]) begin
      drive(vecs[i]);
      exp_q.push_back(vecs[i]);
      @(negedge clk);
      check_row(i, exp_q.pop_front());
      @(posedge clk);
      #1;
    end

    // mul in flight from the last row: reset pulse mid-cycle clears everything at once
    cmp("midmul busy_mul before", 32'(busy_mul), 32'd1);
    cmp("midmul pending before", pending, 32'h300);
    reset = 1'b1;
    #2;
    cmp("midmul busy_mul", 32'(busy_mul), 32'd0);
    cmp("midmul pending", pending, 32'h0);
    cmp("midmul grant1", 32'(grant1), 32'd0);
    reset = 1'b0;
    req1 = 1'b1; op1 = 2'd1; rd1 = 5'd7; rs1_1 = 5'd1; rs2_1 = 5'd2;
    @(negedge clk);
    cmp("post-reset grant1", 32'(grant1), 32'd1);
    @(posedge clk);
    #1;
    drive(idle);
    cmp("post-reset pending", pending, 32'h80);
    cmp("post-reset busy_mul", 32'(busy_mul), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
